// File: rtl/mem_fill_arbiter.sv
// ============================================================================
// Module      : mem_fill_arbiter
// Description : Shares one pipelined, fixed-latency memory port between
//               I-cache and D-cache line fills.
//               D-side misses win arbitration.
//               Each fill issues LINE_WORDS reads, then steers the returning
//               words into the granted cache.
//               Optional macro CRITICAL_WORD_FIRST_EN starts each line at the
//               missed word and wraps around the line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fill_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_miss,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          d_miss,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [15:0]                   mem_rdata,
    input  logic                          mem_rvalid,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [15:0]                   fill_data,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word,
    output logic                          fill_we_i,
    output logic                          fill_we_d,
    output logic                          i_done,
    output logic                          d_done,
    output logic                          i_stall,
    output logic                          d_stall,
    output logic                          busy
);

    localparam int WW    = $clog2(LINE_WORDS);
    localparam int OFF_W = WW + 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [WW-1:0]             issue_cnt_q, issue_cnt_d;
    logic [WW-1:0]             ret_cnt_q, ret_cnt_d;
    logic                      gnt_dside_q, gnt_dside_d;
    logic [ADDR_W-1:OFF_W]     line_q, line_d;
    logic [WW-1:0]             issue_word;
    logic [WW-1:0]             ret_word;
    logic                      accept;

    // The byte offset within the line never reaches the memory directly.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WW-1:0] start_q, start_d;

    // Word order rotates from the missed word; the sum wraps modulo the line.
    assign issue_word = start_q + issue_cnt_q;
    assign ret_word   = start_q + ret_cnt_q;
`else
    assign issue_word = issue_cnt_q;
    assign ret_word   = ret_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            gnt_dside_q <= 1'b0;
            line_q      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            gnt_dside_q <= gnt_dside_d;
            line_q      <= line_d;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q     <= start_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        gnt_dside_d = gnt_dside_q;
        line_d      = line_q;
`ifdef CRITICAL_WORD_FIRST_EN
        start_d     = start_q;
`endif
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        accept      = mem_rvalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

        case (state_q)
            S_IDLE: begin
                // The MEM-stage instruction is older, so its miss goes first.
                if (d_miss) begin
                    gnt_dside_d = 1'b1;
                    line_d      = d_addr[ADDR_W-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = d_addr[OFF_W-1:1];
`endif
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = S_ISSUE;
                end else if (i_miss) begin
                    gnt_dside_d = 1'b0;
                    line_d      = i_addr[ADDR_W-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = i_addr[OFF_W-1:1];
`endif
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = {line_q, issue_word, 1'b0};
                issue_cnt_d = issue_cnt_q + WW'(1);
                if (issue_cnt_q == LAST_WORD) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            S_DONE: begin
                i_done  = ~gnt_dside_q;
                d_done  = gnt_dside_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Returns may overlap issue when memory latency is short.
        if (accept) begin
            fill_data = mem_rdata;
            fill_word = ret_word;
            fill_we_i = ~gnt_dside_q;
            fill_we_d = gnt_dside_q;
            ret_cnt_d = ret_cnt_q + WW'(1);
            if (ret_cnt_q == LAST_WORD) begin
                state_d = S_DONE;
            end
        end
    end

    assign i_stall = i_miss & ~i_done;
    assign d_stall = d_miss & ~d_done;
    assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
// ============================================================================
// Module      : tb_mem_fill_arbiter
// Description : Self-checking bench for mem_fill_arbiter against a fill-level
//               timeline model, with a latency-L in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss;
    logic [15:0] i_addr, d_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i, fill_we_d, i_done, d_done, i_stall, d_stall, busy;

    mem_fill_arbiter #(.LINE_WORDS(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .i_done(i_done), .d_done(d_done),
        .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 4;

    typedef struct {
        logic [15:0] a;
        int          rdy;
    } rd_t;
    rd_t memq[$];

    // memory / requester controls
    bit rand_mode = 0, rand_gaps = 0;
    bit i_fl = 0, d_fl = 0;
    bit i_done_seen = 0, d_done_seen = 0;
    int gap_after = -1, gap_left = 0, n_ret = 0;

    // observation logs
    logic [15:0] log_addr[$];
    int          log_word[$];
    int          n_we_i = 0, n_we_d = 0;
    int          i_done_cnt = 0, d_done_cnt = 0;
    int          last_i_done = -1, last_d_done = -1;

    // fill-level model: one outstanding fill, described by its grant cycle
    bit m_valid = 0, m_side = 0;
    int m_g = 0, m_line = 0, m_start = 0, m_ret = 0, m_done_cyc = -1;

    function automatic logic [15:0] memfn(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    function automatic int start_of(logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return (int'(a) >> 1) & 7;
`else
        return 0;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit          act, e_en, e_acc, e_fin;
        int          k, e_word;
        logic [15:0] e_addr;
        if (rst) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_we", {fill_we_i, fill_we_d}, 0);
            chk("rst_done", {i_done, d_done}, 0);
            chk("rst_busy", busy, 0);
            m_valid = 0;
        end else begin
            act   = m_valid;
            k     = cyc - m_g - 1;
            e_en  = act && (k >= 0) && (k < 8);
            e_acc = act && mem_rvalid && (m_ret < 8);
            e_fin = act && (cyc == m_done_cyc);
            chk("mem_en", mem_en, e_en);
            if (e_en) begin
                e_addr = 16'((m_line << 4) + 2 * ((m_start + k) % 8));
                chk("mem_addr", mem_addr, e_addr);
            end
            chk("fill_we_i", fill_we_i, e_acc && !m_side);
            chk("fill_we_d", fill_we_d, e_acc && m_side);
            if (e_acc) begin
                e_word = (m_start + m_ret) % 8;
                chk("fill_word", fill_word, e_word);
                chk("fill_data", fill_data, memfn(16'((m_line << 4) + 2 * e_word)));
            end
            chk("i_done", i_done, e_fin && !m_side);
            chk("d_done", d_done, e_fin && m_side);
            chk("i_stall", i_stall, i_miss && !(e_fin && !m_side));
            chk("d_stall", d_stall, d_miss && !(e_fin && m_side));
            chk("busy", busy, act);

            if (mem_en) begin
                memq.push_back('{mem_addr, cyc + lat});
                log_addr.push_back(mem_addr);
            end
            if (fill_we_i || fill_we_d) log_word.push_back(int'(fill_word));
            if (fill_we_i) n_we_i++;
            if (fill_we_d) n_we_d++;
            if (i_done) begin i_done_seen = 1; i_done_cnt++; last_i_done = cyc; end
            if (d_done) begin d_done_seen = 1; d_done_cnt++; last_d_done = cyc; end

            if (e_acc) begin
                m_ret++;
                if (m_ret == 8) m_done_cyc = cyc + 1;
            end
            if (e_fin) begin
                m_valid = 0;
            end else if (!act && (d_miss || i_miss)) begin
                m_valid    = 1;
                m_side     = d_miss;
                m_line     = int'(d_miss ? d_addr : i_addr) >> 4;
                m_start    = start_of(d_miss ? d_addr : i_addr);
                m_g        = cyc;
                m_ret      = 0;
                m_done_cyc = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (i_done_seen) begin
            i_miss = 0; i_done_seen = 0;
        end else if (rand_mode) begin
            if (!busy) i_fl = 0;
            if (i_miss && $urandom_range(0, 39) == 0) begin
                i_miss = 0; i_fl = 1;
            end else if (!i_miss && !i_fl && $urandom_range(0, 3) == 0) begin
                i_miss = 1; i_addr = 16'($urandom);
            end
        end
        if (d_done_seen) begin
            d_miss = 0; d_done_seen = 0;
        end else if (rand_mode) begin
            if (!busy) d_fl = 0;
            if (d_miss && $urandom_range(0, 39) == 0) begin
                d_miss = 0; d_fl = 1;
            end else if (!d_miss && !d_fl && $urandom_range(0, 3) == 0) begin
                d_miss = 1; d_addr = 16'($urandom);
            end
        end
        mem_rvalid = 0;
        mem_rdata  = 16'h0;
        if (gap_left > 0) begin
            gap_left--;
        end else if (memq.size() > 0 && memq[0].rdy <= cyc &&
                     !(rand_gaps && $urandom_range(0, 3) == 0)) begin
            mem_rvalid = 1;
            mem_rdata  = memfn(memq[0].a);
            void'(memq.pop_front());
            n_ret++;
            if (n_ret == gap_after) gap_left = 3;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            if (!busy && memq.size() == 0 && !i_miss && !d_miss) begin
                ok = 1;
                break;
            end
            step();
        end
        chk("wait_idle", ok, 1);
        log_addr.delete();
        log_word.delete();
        n_we_i = 0;
        n_we_d = 0;
        n_ret  = 0;
    endtask

    task automatic wait_i_done(int prev);
        for (int n = 0; n < 100 && i_done_cnt == prev; n++) step();
        chk("i_done_timeout", i_done_cnt != prev, 1);
    endtask

    task automatic wait_d_done(int prev);
        for (int n = 0; n < 100 && d_done_cnt == prev; n++) step();
        chk("d_done_timeout", d_done_cnt != prev, 1);
    endtask

    task automatic chk_line(string nm, logic [15:0] a0, logic [15:0] a7, int w0);
        chk({nm, "_nissue"}, log_addr.size(), 8);
        if (log_addr.size() >= 8 && log_word.size() >= 8) begin
            chk({nm, "_addr0"}, log_addr[0], a0);
            chk({nm, "_addr7"}, log_addr[7], a7);
            chk({nm, "_word0"}, log_word[0], w0);
        end
    endtask

    initial begin
        int t0, ic, dc;
        rst = 1; i_miss = 0; d_miss = 0; i_addr = 0; d_addr = 0;
        mem_rvalid = 0; mem_rdata = 0;
        repeat (3) step();
        rst = 0;
        step();

        // I-only miss, L=4
        wait_idle();
        t0 = cyc; ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h1236;
        wait_i_done(ic);
        chk("t1_done_cyc", last_i_done - t0, 13);
        chk("t1_we_i", n_we_i, 8);
        chk("t1_we_d", n_we_d, 0);
`ifdef CRITICAL_WORD_FIRST_EN
        chk_line("t1", 16'h1236, 16'h1234, 3);
`else
        chk_line("t1", 16'h1230, 16'h123E, 0);
`endif

        // simultaneous misses: D first, then I
        wait_idle();
        t0 = cyc; ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h4452;
        d_miss = 1; d_addr = 16'h8004;
        wait_i_done(ic);
        chk("t2_d_done", last_d_done - t0, 13);
        chk("t2_i_done", last_i_done - t0, 27);
        chk("t2_nissue", log_addr.size(), 16);
        if (log_addr.size() >= 16) begin
`ifdef CRITICAL_WORD_FIRST_EN
            chk("t2_d_addr0", log_addr[0], 16'h8004);
            chk("t2_i_addr0", log_addr[8], 16'h4452);
`else
            chk("t2_d_addr0", log_addr[0], 16'h8000);
            chk("t2_i_addr0", log_addr[8], 16'h4450);
`endif
        end

        // 3-cycle gap between words 3 and 4
        wait_idle();
        gap_after = 4;
        t0 = cyc; dc = d_done_cnt;
        d_miss = 1; d_addr = 16'h0A10;
        wait_d_done(dc);
        chk("t3_done_cyc", last_d_done - t0, 16);
        chk("t3_we_d", n_we_d, 8);
        gap_after = -1;

        // reset during ISSUE at issue_cnt=5
        wait_idle();
        t0 = cyc; ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h2000;
        repeat (6) step();
        rst = 1; i_miss = 0; memq.delete();
        i_done_seen = 0; d_done_seen = 0;
        repeat (2) step();
        rst = 0;
        repeat (10) step();
        chk("t4_no_done", i_done_cnt, ic);
        wait_idle();
        t0 = cyc; ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h0040;
        wait_i_done(ic);
        chk("t4_done_cyc", last_i_done - t0, 13);
        chk_line("t4", 16'h0040, 16'h004E, 0);

        // requester drops its miss at cycle 3
        wait_idle();
        t0 = cyc; ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h3338;
        repeat (3) step();
        i_miss = 0;
        wait_i_done(ic);
        repeat (5) step();
        chk("t5_done_cyc", last_i_done - t0, 13);
        chk("t5_done_once", i_done_cnt - ic, 1);
        chk("t5_we_i", n_we_i, 8);

`ifdef CRITICAL_WORD_FIRST_EN
        wait_idle();
        ic = i_done_cnt;
        i_miss = 1; i_addr = 16'h123A;
        wait_i_done(ic);
        chk_line("t6", 16'h123A, 16'h1238, 5);
        if (log_addr.size() >= 8 && log_word.size() >= 8) begin
            chk("t6_addr3", log_addr[3], 16'h1230);
            chk("t6_word3", log_word[3], 0);
            chk("t6_word7", log_word[7], 4);
        end
`endif

        // randomized traffic with varying latency and return gaps
        for (int b = 0; b < 3; b++) begin
            wait_idle();
            lat = $urandom_range(1, 6);
            rand_mode = 1; rand_gaps = 1;
            repeat (1500) step();
            rand_mode = 0; rand_gaps = 0;
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
